// File: rtl/btn_debounce_pair_if.sv
// rtl/btn_debounce_pair_if.sv - raw button inputs and conditioned outputs toward the ALU/LED stage
interface btn_debounce_pair_if;
    logic       btn1;
    logic       btn2;
    logic       btn1_db;
    logic       btn2_db;
    logic       btn1_press;
    logic       btn2_press;
    logic       btn1_release;
    logic       btn2_release;
    logic [1:0] op_sel;
    logic       op_change;

    modport master (
        output btn1, btn2,
        input  btn1_db, btn2_db, btn1_press, btn2_press,
        input  btn1_release, btn2_release, op_sel, op_change
    );

    modport slave (
        input  btn1, btn2,
        output btn1_db, btn2_db, btn1_press, btn2_press,
        output btn1_release, btn2_release, op_sel, op_change
    );
endinterface

// File: rtl/btn_debounce_pair.sv
// rtl/btn_debounce_pair.sv - two-button synchroniser/debouncer producing levels, strobes and ALU op select
module btn_debounce_pair #(
    parameter int CNT_W           = 19,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic               clk,
    input  logic               rst_n,
    btn_debounce_pair_if.slave bus
);

    typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 1 is btn1, index 0 is btn2, matching the bit order of op_sel.
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       db_q, db_d;
    logic [1:0]       press_q, press_d;
    logic [1:0]       rel_q, rel_d;
    logic [1:0]       op_prev_q, op_prev_d;
    logic             op_change_q, op_change_d;

    assign raw = {bus.btn1, bus.btn2};

    always_comb begin
        sync1_d     = raw;
        sync2_d     = sync1_q;
        db_d        = db_q;
        press_d     = 2'b00;
        rel_d       = 2'b00;
        op_prev_d   = db_q;
        op_change_d = (db_q != op_prev_q);
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                REL: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = WAIT_P;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_P: begin
                    if (sync2_q[i]) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == TERM_CNT) begin
                        state_d[i] = PRS;
                        db_d[i]    = 1'b0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                PRS: begin
                    if (sync2_q[i]) begin
                        state_d[i] = WAIT_R;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_R: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == TERM_CNT) begin
                        state_d[i] = REL;
                        db_d[i]    = 1'b1;
                        rel_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            db_q        <= 2'b11;
            press_q     <= 2'b00;
            rel_q       <= 2'b00;
            op_prev_q   <= 2'b11;
            op_change_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            op_prev_q   <= op_prev_d;
            op_change_q <= op_change_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.btn1_db      = db_q[1];
    assign bus.btn2_db      = db_q[0];
    assign bus.btn1_press   = press_q[1];
    assign bus.btn2_press   = press_q[0];
    assign bus.btn1_release = rel_q[1];
    assign bus.btn2_release = rel_q[0];
    assign bus.op_sel       = db_q;
    assign bus.op_change    = op_change_q;

endmodule

// File: tb/tb_btn_debounce_pair.sv
// tb/tb_btn_debounce_pair.sv - scoreboard bench for btn_debounce_pair with DEBOUNCE_CYCLES=4
module tb_btn_debounce_pair;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic       chg;
        logic [1:0] op;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    btn_debounce_pair_if bus ();

    btn_debounce_pair #(
        .CNT_W          (19),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [1:0] p, input logic [1:0] r,
                        input logic ch, input logic [1:0] op);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.chg = ch; e.op = op;
        exp_q.push_back(e);
    endtask

    // Accepted transition sampled first at edge e: strobe at e+6, op_change at e+7.
    task automatic expect_edge(input int e, input logic [1:0] p, input logic [1:0] r,
                               input logic [1:0] op);
        push(e + 6, p, r, 1'b0, op);
        push(e + 7, 2'b00, 2'b00, 1'b1, op);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t       e;
        logic [1:0] p, r, op, db;
        logic       ch;
        forever begin
            @(negedge clk);
            p  = {bus.btn1_press, bus.btn2_press};
            r  = {bus.btn1_release, bus.btn2_release};
            ch = bus.op_change;
            op = bus.op_sel;
            db = {bus.btn1_db, bus.btn2_db};
            if ((p != 2'b00) || (r != 2'b00) || ch) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b chg=%b op=%b",
                             cyc, p, r, ch, op);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.press !== p || e.rel !== r || e.chg !== ch ||
                        e.op !== op || db !== e.op) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d press=%b rel=%b chg=%b op=%b db=%b expected cyc=%0d press=%b rel=%b chg=%b op=%b",
                                 cyc, p, r, ch, op, db, e.cyc, e.press, e.rel, e.chg, e.op);
                    end
                end
            end
        end
    endtask

    initial begin
        int e;
        rst_n    = 1'b0;
        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_db", {6'b0, bus.btn1_db, bus.btn2_db}, 8'b11);
        chk("rst_op_sel", {6'b0, bus.op_sel}, 8'b11);
        chk("rst_pulses", {3'b0, bus.btn1_press, bus.btn2_press, bus.btn1_release,
                           bus.btn2_release, bus.op_change}, 8'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Clean press and release of btn1
        e = cyc + 1; bus.btn1 = 1'b0;
        expect_edge(e, 2'b10, 2'b00, 2'b01);
        repeat (12) @(negedge clk);
        e = cyc + 1; bus.btn1 = 1'b1;
        expect_edge(e, 2'b00, 2'b10, 2'b11);
        repeat (12) @(negedge clk);

        // Bounce reject on btn2: low 3, high 1, low 2, high
        bus.btn2 = 1'b0; repeat (3) @(negedge clk);
        bus.btn2 = 1'b1; repeat (1) @(negedge clk);
        bus.btn2 = 1'b0; repeat (2) @(negedge clk);
        bus.btn2 = 1'b1; repeat (15) @(negedge clk);
        chk("bounce_db", {6'b0, bus.btn1_db, bus.btn2_db}, 8'b11);

        // Bounce then settle on btn2: low 2, high 1, low held
        bus.btn2 = 1'b0; repeat (2) @(negedge clk);
        bus.btn2 = 1'b1; repeat (1) @(negedge clk);
        e = cyc + 1; bus.btn2 = 1'b0;
        expect_edge(e, 2'b01, 2'b00, 2'b10);
        repeat (12) @(negedge clk);
        e = cyc + 1; bus.btn2 = 1'b1;
        expect_edge(e, 2'b00, 2'b01, 2'b11);
        repeat (12) @(negedge clk);

        // Simultaneous press and release
        e = cyc + 1; bus.btn1 = 1'b0; bus.btn2 = 1'b0;
        expect_edge(e, 2'b11, 2'b00, 2'b00);
        repeat (12) @(negedge clk);
        e = cyc + 1; bus.btn1 = 1'b1; bus.btn2 = 1'b1;
        expect_edge(e, 2'b00, 2'b11, 2'b11);
        repeat (12) @(negedge clk);

        // Reset after three counting clocks, btn1 held through reset release
        bus.btn1 = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_db", {6'b0, bus.btn1_db, bus.btn2_db}, 8'b11);
        chk("midrst_pulses", {3'b0, bus.btn1_press, bus.btn2_press, bus.btn1_release,
                              bus.btn2_release, bus.op_change}, 8'b0);
        repeat (2) @(negedge clk);
        e = cyc + 1; rst_n = 1'b1;
        expect_edge(e, 2'b10, 2'b00, 2'b01);
        repeat (12) @(negedge clk);
        chk("midrst_held_db", {6'b0, bus.btn1_db, bus.btn2_db}, 8'b01);
        e = cyc + 1; bus.btn1 = 1'b1;
        expect_edge(e, 2'b00, 2'b10, 2'b11);
        repeat (15) @(negedge clk);

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pair.md
Name: btn_debounce_pair

Overview:
Input-conditioning stage that sits directly upstream of the board ALU. It takes the two raw, bouncy, active-low push buttons (btn1, btn2) and resynchronises and debounces each one. It delivers clean button levels, one-cycle press/release strobes, a 2-bit operation select, and a change strobe to the ALU/LED stage. Target board clock is 27 MHz.

Parameters:
CNT_W, 19, width of each per-button debounce counter
DEBOUNCE_CYCLES, 270000, clocks a synchronised level must hold before it is accepted (10 ms at 27 MHz); legal range 2 .. 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn1  input  1  raw button 1, active-low (0 = pressed), asynchronous to clk
btn2  input  1  raw button 2, active-low (0 = pressed), asynchronous to clk
btn1_db  output  1  debounced btn1 level, active-low
btn2_db  output  1  debounced btn2 level, active-low
btn1_press  output  1  one-cycle pulse when btn1_db goes 1->0
btn2_press  output  1  one-cycle pulse when btn2_db goes 1->0
btn1_release  output  1  one-cycle pulse when btn1_db goes 0->1
btn2_release  output  1  one-cycle pulse when btn2_db goes 0->1
op_sel  output  2  {btn1_db, btn2_db}, consumed by the ALU as its opcode
op_change  output  1  one-cycle pulse the cycle after op_sel takes a new value

Behaviour:
- Reset (rst_n=0, asynchronous): synchroniser flops = 1; FSMs = REL; counters = 0; btnX_db = 1; op_sel = 2'b11; all pulse outputs = 0; op_change reference register = 2'b11.
- Synchroniser: two-flop chain per button. sync_X is the raw level delayed 2 clocks.
- Per-button FSM states: REL (stable released), WAIT_P (candidate press), PRS (stable pressed), WAIT_R (candidate release).
- REL: sync_X=0 -> WAIT_P with cnt=0; otherwise hold.
- WAIT_P:
  - sync_X=1 -> back to REL, cnt=0. This is a bounce abort: no pulse, db unchanged.
  - Otherwise, cnt==DEBOUNCE_CYCLES-1 -> PRS; btnX_db<=0; btnX_press=1 for one cycle.
  - Otherwise cnt++.
- PRS: sync_X=1 -> WAIT_R with cnt=0.
- WAIT_R: mirror of WAIT_P. sync_X=0 aborts to PRS. Terminal count -> REL, btnX_db<=1, btnX_release=1 for one cycle.
- Latency: a raw level held stable is first sampled at clk edge E. btnX_db and the matching pulse change at edge E+2+DEBOUNCE_CYCLES, then stay registered.
- Any glitch shorter than DEBOUNCE_CYCLES synchronised clocks produces no output change. Every new candidate restarts the count from 0.
- Counter never wraps: terminal compare happens before increment. CNT_W must hold DEBOUNCE_CYCLES-1.
- op_sel is combinational from the db registers: {btn1_db, btn2_db}.
- op_change: a register holds the previous op_sel. op_change=1 for exactly one cycle, the cycle after op_sel differs from it.
- If both buttons settle on the same edge, the result is one op_change pulse and both press/release pulses in that same cycle.
- press and release of one button are never asserted together; buttons are fully independent.
- Reset mid-count: the count is discarded and no pulse is emitted.
- Button held pressed through reset release: it is debounced normally from REL and yields a btnX_press.
- Pulses are never stretched or merged; back-to-back accepted transitions are at least DEBOUNCE_CYCLES+1 clocks apart.

Test Plan:
(DEBOUNCE_CYCLES=4 for all directed tests.)
- Reset: assert rst_n=0 with buttons released -> btn1_db=btn2_db=1, op_sel=2'b11, all pulses 0. Release reset and idle 20 clks -> no pulses.
- Clean press: btn1 1->0 sampled at edge E and held -> btn1_db=0 and btn1_press=1 at edge E+6 only; op_sel=2'b01; op_change=1 at E+7 for one cycle.
- Bounce reject: btn2 toggles low 3 clks, high 1 clk, low 2 clks, then high -> btn2_db stays 1; no press, release or op_change pulses.
- Bounce then settle: btn2 low 2 clks, high 1 clk, then low held from edge F -> btn2_press exactly once at F+6; op_sel=2'b10.
- Simultaneous: both buttons 1->0 sampled at the same edge -> both press pulses in the same cycle; op_sel 11->00; single op_change pulse. Both released together -> both release pulses, op_sel=2'b11.
- Reset mid-count: btn1 low, rst_n=0 after 3 counting clks, btn1 held low through reset release -> no pulse during reset. btn1_press fires 2+4 clks after the first post-reset sample.
